// File: rtl/qspi_xfer_arbiter.sv
// Round-robin arbiter sharing one QSPI controller between NUM_REQ requesters.
// Latches the winner's fields, pulses start, then returns data/ack or a watchdog error.
module qspi_xfer_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 4,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int COMMAND_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*COMMAND_WIDTH-1:0]  req_command,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                ack,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              rsp_err,
    output logic                              ctl_start,
    output logic [COMMAND_WIDTH-1:0]          ctl_command,
    output logic [ADDRESS_WIDTH-1:0]          ctl_address,
    output logic [DATA_WIDTH-1:0]             ctl_data_in,
    input  logic                              ctl_busy,
    input  logic                              ctl_done,
    input  logic [DATA_WIDTH-1:0]             ctl_data_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                     state, state_n;
    logic [IW-1:0]              ptr, ptr_n, win, win_n, pick;
    logic                       found;
    logic [WW-1:0]              wd, wd_n;
    logic [NUM_REQ-1:0]         gnt_n, ack_n;
    logic                       start_n, err_n;
    logic [DATA_WIDTH-1:0]      rdata_n, din_n;
    logic [COMMAND_WIDTH-1:0]   cmd_n;
    logic [ADDRESS_WIDTH-1:0]   addr_n;

    // First asserted request at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        wd_n    = wd;
        gnt_n   = gnt;
        ack_n   = '0;
        start_n = 1'b0;
        cmd_n   = ctl_command;
        addr_n  = ctl_address;
        din_n   = ctl_data_in;
        rdata_n = rsp_data;
        err_n   = rsp_err;
        case (state)
            IDLE: begin
                if (found && !ctl_busy) begin
                    win_n        = pick;
                    cmd_n        = req_command[pick*COMMAND_WIDTH +: COMMAND_WIDTH];
                    addr_n       = req_address[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    din_n        = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
                    gnt_n        = '0;
                    gnt_n[pick]  = 1'b1;
                    start_n      = 1'b1;
                    wd_n         = '0;
                    state_n      = WAIT;
                end
            end
            WAIT: begin
                wd_n = wd + 1'b1;
                // ctl_start still high means the controller has not seen this transfer yet
                if (ctl_done && !ctl_start) begin
                    rdata_n    = ctl_data_out;
                    err_n      = 1'b0;
                    ack_n[win] = 1'b1;
                    gnt_n      = '0;
                    state_n    = RESP;
                end else if (TIMEOUT_CYCLES != 0 && wd == WW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_n    = '0;
                    err_n      = 1'b1;
                    ack_n[win] = 1'b1;
                    gnt_n      = '0;
                    state_n    = RESP;
                end
            end
            RESP: begin
                ptr_n   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            win         <= '0;
            wd          <= '0;
            gnt         <= '0;
            ack         <= '0;
            ctl_start   <= 1'b0;
            ctl_command <= '0;
            ctl_address <= '0;
            ctl_data_in <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            win         <= win_n;
            wd          <= wd_n;
            gnt         <= gnt_n;
            ack         <= ack_n;
            ctl_start   <= start_n;
            ctl_command <= cmd_n;
            ctl_address <= addr_n;
            ctl_data_in <= din_n;
            rsp_data    <= rdata_n;
            rsp_err     <= err_n;
        end
    end

endmodule

// File: tb/tb_qspi_xfer_arbiter.sv
// Directed bench for qspi_xfer_arbiter: one instance with the default watchdog,
// one with a 16-cycle watchdog; ack results are checked against a scoreboard queue.
module tb_qspi_xfer_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_a, req_b;
    logic [15:0] req_command;
    logic [63:0] req_address;
    logic [7:0]  req_data;
    logic        busy, done_a, done_b;
    logic [3:0]  dout;

    logic [1:0]  gnt_a, ack_a, gnt_b, ack_b;
    logic [3:0]  rsp_data_a, rsp_data_b, din_a, din_b;
    logic        rsp_err_a, rsp_err_b, start_a, start_b;
    logic [7:0]  cmd_a, cmd_b;
    logic [31:0] addr_a, addr_b;

    typedef struct {
        logic [1:0] ack;
        logic [3:0] data;
        logic       err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    qspi_xfer_arbiter #(.NUM_REQ(2), .DATA_WIDTH(4), .ADDRESS_WIDTH(32),
                        .COMMAND_WIDTH(8), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .reset(reset), .req(req_a),
        .req_command(req_command), .req_address(req_address), .req_data(req_data),
        .gnt(gnt_a), .ack(ack_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
        .ctl_start(start_a), .ctl_command(cmd_a), .ctl_address(addr_a), .ctl_data_in(din_a),
        .ctl_busy(busy), .ctl_done(done_a), .ctl_data_out(dout)
    );

    qspi_xfer_arbiter #(.NUM_REQ(2), .DATA_WIDTH(4), .ADDRESS_WIDTH(32),
                        .COMMAND_WIDTH(8), .TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .reset(reset), .req(req_b),
        .req_command(req_command), .req_address(req_address), .req_data(req_data),
        .gnt(gnt_b), .ack(ack_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .ctl_start(start_b), .ctl_command(cmd_b), .ctl_address(addr_b), .ctl_data_in(din_b),
        .ctl_busy(busy), .ctl_done(done_b), .ctl_data_out(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit b, input logic [1:0] g, input logic [3:0] d, input logic er);
        exp_t e;
        e.ack  = g;
        e.data = d;
        e.err  = er;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic expect_ack(input bit b, input string tag, input int budget);
        exp_t e;
        int   n;
        bit   have;
        n = 0;
        while (((b ? ack_b : ack_a) == 2'b00) && n < budget) begin
            step();
            n++;
        end
        e.ack  = '0;
        e.data = '0;
        e.err  = 1'b0;
        have   = b ? (qb.size() != 0) : (qa.size() != 0);
        if (have) begin
            if (b) e = qb.pop_front();
            else   e = qa.pop_front();
        end
        chk({tag, "_sb"},   64'(have), 64'(1));
        chk({tag, "_ack"},  64'(b ? ack_b : ack_a), 64'(e.ack));
        chk({tag, "_data"}, 64'(b ? rsp_data_b : rsp_data_a), 64'(e.data));
        chk({tag, "_err"},  64'(b ? rsp_err_b : rsp_err_a), 64'(e.err));
        chk({tag, "_gnt"},  64'(b ? gnt_b : gnt_a), 64'(0));
    endtask

    // Drive done on instance A after waitc cycles and check the resulting ack.
    task automatic finish_a(input string tag, input logic [1:0] g, input logic [3:0] d, input int waitc);
        push(1'b0, g, d, 1'b0);
        repeat (waitc) step();
        done_a = 1'b1;
        dout   = d;
        step();
        done_a = 1'b0;
        expect_ack(1'b0, tag, 0);
    endtask

    initial begin
        reset       = 1'b1;
        req_a       = '0;
        req_b       = '0;
        req_command = {8'h3C, 8'hA5};
        req_address = {32'hCAFEF00D, 32'h12345678};
        req_data    = {4'h6, 4'hF};
        busy        = 1'b0;
        done_a      = 1'b0;
        done_b      = 1'b0;
        dout        = 4'h0;
        step();
        step();
        chk("rst_gnt",   64'(gnt_a), 64'(0));
        chk("rst_ack",   64'(ack_a), 64'(0));
        chk("rst_start", 64'(start_a), 64'(0));
        chk("rst_cmd",   64'(cmd_a), 64'(0));
        chk("rst_addr",  64'(addr_a), 64'(0));
        chk("rst_rsp",   64'({rsp_err_a, rsp_data_a, din_a}), 64'(0));
        reset = 1'b0;
        step();

        // single transfer from requester 0
        req_a = 2'b01;
        step();
        chk("t1_start", 64'(start_a), 64'(1));
        chk("t1_gnt",   64'(gnt_a), 64'(2'b01));
        chk("t1_cmd",   64'(cmd_a), 64'(8'hA5));
        chk("t1_addr",  64'(addr_a), 64'(32'h12345678));
        chk("t1_din",   64'(din_a), 64'(4'hF));
        req_command[7:0] = 8'h00;
        step();
        chk("t1_pulse", 64'(start_a), 64'(0));
        repeat (17) step();
        chk("t1_hold_cmd", 64'(cmd_a), 64'(8'hA5));
        chk("t1_no_ack",   64'(ack_a), 64'(0));
        finish_a("t1", 2'b01, 4'h3, 1);
        req_a = 2'b00;
        req_command[7:0] = 8'hA5;
        step();
        step();

        // both requesting from reset: grants alternate
        reset = 1'b1;
        req_a = 2'b11;
        step();
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_start", 64'(start_a), 64'(1));
            chk("rr_gnt",   64'(gnt_a), 64'(g));
            finish_a("rr", g, 4'(i + 5), 2);
            if (i == 3) req_a = 2'b00;
            step();
            chk("rr_gap", 64'(start_a), 64'(0));
            step();
        end
        chk("rr_idle", 64'(start_a), 64'(0));

        // watchdog abort on the 16-cycle instance, then the next request
        req_b = 2'b01;
        dout  = 4'hB;
        step();
        chk("wd_start", 64'(start_b), 64'(1));
        chk("wd_gnt",   64'(gnt_b), 64'(2'b01));
        push(1'b1, 2'b01, 4'h0, 1'b1);
        repeat (15) step();
        chk("wd_early", 64'(ack_b), 64'(0));
        step();
        expect_ack(1'b1, "wd", 0);
        req_b = 2'b10;
        step();
        chk("wd_hold_err", 64'(rsp_err_b), 64'(1));
        step();
        chk("wd_next_start", 64'(start_b), 64'(1));
        chk("wd_next_gnt",   64'(gnt_b), 64'(2'b10));
        push(1'b1, 2'b10, 4'hB, 1'b0);
        repeat (2) step();
        done_b = 1'b1;
        step();
        done_b = 1'b0;
        expect_ack(1'b1, "wd_next", 0);
        req_b = 2'b00;
        step();
        step();

        // controller busy externally
        busy  = 1'b1;
        req_a = 2'b10;
        step();
        step();
        chk("busy_gnt",   64'(gnt_a), 64'(0));
        chk("busy_start", 64'(start_a), 64'(0));
        busy = 1'b0;
        step();
        chk("busy_start_after", 64'(start_a), 64'(1));
        chk("busy_gnt_after",   64'(gnt_a), 64'(2'b10));
        chk("busy_cmd",         64'(cmd_a), 64'(8'h3C));
        finish_a("busy", 2'b10, 4'h7, 3);
        req_a = 2'b00;
        step();
        step();

        // reset in the middle of WAIT
        req_a = 2'b01;
        step();
        chk("rst_mid_start", 64'(start_a), 64'(1));
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_gnt",   64'(gnt_a), 64'(0));
        chk("rst_mid_ack",   64'(ack_a), 64'(0));
        chk("rst_mid_start0", 64'(start_a), 64'(0));
        reset = 1'b0;
        step();
        chk("rst_fresh_start", 64'(start_a), 64'(1));
        chk("rst_fresh_gnt",   64'(gnt_a), 64'(2'b01));
        finish_a("rst_fresh", 2'b01, 4'h2, 4);
        req_a = 2'b00;
        step();
        step();

        // request dropped during WAIT still gets its ack
        req_a = 2'b01;
        step();
        chk("drop_start", 64'(start_a), 64'(1));
        step();
        req_a = 2'b00;
        finish_a("drop", 2'b01, 4'h9, 3);
        step();
        step();

        // done on the same cycle as the watchdog limit counts as success
        req_b = 2'b01;
        step();
        chk("race_start", 64'(start_b), 64'(1));
        push(1'b1, 2'b01, 4'hC, 1'b0);
        repeat (15) step();
        done_b = 1'b1;
        dout   = 4'hC;
        step();
        done_b = 1'b0;
        req_b  = 2'b00;
        expect_ack(1'b1, "race", 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
